// File: rtl/btn_evt_pkg.sv
// Shared constants, defaults and round-robin pick helper for the button event arbiter.
package btn_evt_pkg;

   localparam int unsigned MAX_BTN    = 8;
   localparam int unsigned N_BTN_DEF  = 4;
   localparam int unsigned ID_W_DEF   = 2;
   localparam int unsigned DEPTH_DEF  = 4;
   localparam int unsigned DROP_W_DEF = 8;

   typedef enum logic [1:0] {
      EVT_SELECT  = 2'd0,
      EVT_CONFIRM = 2'd1,
      EVT_CANCEL  = 2'd2,
      EVT_COIN    = 2'd3
   } evt_id_e;

   typedef struct packed {
      logic       hit;
      logic [2:0] idx;
   } rr_pick_t;

   // First set bit of pend[n-1:0] searching upward from ptr, wrapping at n (ptr < n assumed).
   function automatic rr_pick_t rr_pick(input logic [MAX_BTN-1:0] pend,
                                        input logic [2:0] ptr,
                                        input int unsigned n);
      rr_pick_t    r;
      int unsigned j;
      r.hit = 1'b0;
      r.idx = '0;
      for (int unsigned k = 0; k < MAX_BTN; k++) begin
         if (k < n) begin
            j = 32'(ptr) + k;
            if (j >= n) j = j - n;
            if (!r.hit && pend[j[2:0]]) begin
               r.hit = 1'b1;
               r.idx = j[2:0];
            end
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/btn_event_arbiter_fifo.sv
// Synchronous event FIFO; pointers carry one extra wrap bit so full/empty fall out of comparison.
module evt_fifo
   import btn_evt_pkg::*;
#(
   parameter int unsigned W     = ID_W_DEF,
   parameter int unsigned DEPTH = DEPTH_DEF,
   localparam int unsigned AW   = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr,
   input  logic          push,
   input  logic          pop,
   input  logic [W-1:0]  din,
   output logic [W-1:0]  dout,
   output logic          full,
   output logic          empty,
   output logic [AW:0]   count
);

   logic [W-1:0] mem [DEPTH];
   logic [AW:0]  wr_ptr;
   logic [AW:0]  rd_ptr;
   logic         do_push;
   logic         do_pop;

   always_comb begin
      empty   = (wr_ptr == rd_ptr);
      full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
      count   = wr_ptr - rd_ptr;
      do_push = push && !full;
      do_pop  = pop && !empty;
      dout    = mem[rd_ptr[AW-1:0]];
   end

   always_ff @(posedge clk) begin
      if (!rst || clr) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst && !clr && do_push) mem[wr_ptr[AW-1:0]] <= din;
   end

endmodule

// File: rtl/btn_event_arbiter.sv
// Latches debounced button pulses as pending requests, grants them round-robin into an event FIFO.
module btn_event_arbiter
   import btn_evt_pkg::*;
#(
   parameter int unsigned N_BTN  = N_BTN_DEF,
   parameter int unsigned ID_W   = ID_W_DEF,
   parameter int unsigned DEPTH  = DEPTH_DEF,
   parameter int unsigned DROP_W = DROP_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              flush,
   input  logic [N_BTN-1:0]  btn_pulse,
   output logic              evt_valid,
   output logic [ID_W-1:0]   evt_id,
   input  logic              evt_ready,
   output logic [N_BTN-1:0]  pend,
   output logic [DROP_W-1:0] drop_cnt,
   output logic              overflow
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [ID_W-1:0]    rr_ptr;
   logic [ID_W-1:0]    rr_next;
   logic [MAX_BTN-1:0] pend_ext;
   rr_pick_t           pick;
   logic               grant;
   logic [N_BTN-1:0]   pend_n;
   logic [N_BTN-1:0]   drops;
   int unsigned        n_drop;
   logic [DROP_W+3:0]  drop_sum;
   logic [DROP_W-1:0]  drop_next;

   logic [ID_W-1:0]    fifo_dout;
   logic               fifo_full;
   logic               fifo_empty;
   logic [AW:0]        fifo_count;

   evt_fifo #(
      .W     (ID_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .clr   (flush),
      .push  (grant),
      .pop   (evt_ready),
      .din   (ID_W'(pick.idx)),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   assign evt_valid = (fifo_count != '0);
   assign evt_id    = fifo_empty ? '0 : fifo_dout;

   always_comb begin
      pend_ext             = '0;
      pend_ext[N_BTN-1:0]  = pend;
      pick                 = rr_pick(pend_ext, 3'(rr_ptr), N_BTN);
      grant                = pick.hit && !fifo_full;
      rr_next              = (pick.idx == 3'(N_BTN - 1)) ? '0 : ID_W'(pick.idx + 3'd1);
   end

   // A pulse on the bit being granted this cycle re-arms it rather than counting as a drop.
   always_comb begin
      pend_n = pend;
      drops  = '0;
      n_drop = 0;
      for (int unsigned i = 0; i < N_BTN; i++) begin
         if (grant && (pick.idx == 3'(i))) pend_n[i] = 1'b0;
         if (en && btn_pulse[i]) begin
            if (pend[i] && !(grant && (pick.idx == 3'(i)))) begin
               drops[i] = 1'b1;
               n_drop   = n_drop + 1;
            end
            pend_n[i] = 1'b1;
         end
      end
      drop_sum  = {4'b0000, drop_cnt} + (DROP_W + 4)'(n_drop);
      drop_next = (drop_sum[DROP_W+3:DROP_W] != '0) ? '1 : drop_sum[DROP_W-1:0];
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         pend     <= '0;
         rr_ptr   <= '0;
         drop_cnt <= '0;
         overflow <= 1'b0;
      end else if (flush) begin
         pend     <= '0;
         rr_ptr   <= '0;
         overflow <= 1'b0;
      end else begin
         pend     <= pend_n;
         drop_cnt <= drop_next;
         if (grant)  rr_ptr   <= rr_next;
         if (|drops) overflow <= 1'b1;
      end
   end

endmodule

// File: tb/tb_btn_event_arbiter.sv
// Bench for btn_event_arbiter: directed vector table, hand-written corner sequences, random vs. queue model.
module tb_btn_event_arbiter;

   localparam int N = 4;
   localparam int D = 4;

   logic       clk = 1'b0;
   logic       rst, en, flush, evt_ready;
   logic [3:0] btn_pulse;
   logic       evt_valid;
   logic [1:0] evt_id;
   logic [3:0] pend;
   logic [7:0] drop_cnt;
   logic       overflow;

   btn_event_arbiter #(
      .N_BTN  (4),
      .ID_W   (2),
      .DEPTH  (4),
      .DROP_W (8)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .flush     (flush),
      .btn_pulse (btn_pulse),
      .evt_valid (evt_valid),
      .evt_id    (evt_id),
      .evt_ready (evt_ready),
      .pend      (pend),
      .drop_cnt  (drop_cnt),
      .overflow  (overflow)
   );

   always #5 clk = ~clk;

   int n_err = 0;
   int n_checks = 0;
   bit use_model = 0;

   // Behavioural model: pending set, pointer, event queue, drop counter.
   bit [3:0] m_pend;
   int       m_ptr;
   int       m_q[$];
   int       m_drop;
   bit       m_ovf;
   int       pops[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_step(input bit r, input bit e, input bit f, input logic [3:0] p, input bit rd);
      int g;
      int nd;
      bit [3:0] np;
      if (!r) begin
         m_pend = '0; m_q.delete(); m_ptr = 0; m_drop = 0; m_ovf = 0;
         return;
      end
      if (f) begin
         m_pend = '0; m_q.delete(); m_ptr = 0; m_ovf = 0;
         return;
      end
      g = -1;
      if (m_q.size() < D) begin
         for (int k = 0; k < N; k++) begin
            int j = (m_ptr + k) % N;
            if (g < 0 && m_pend[j]) g = j;
         end
      end
      if (rd && m_q.size() > 0) void'(m_q.pop_front());
      np = m_pend;
      if (g >= 0) np[g] = 1'b0;
      nd = 0;
      if (e) begin
         for (int i = 0; i < N; i++) begin
            if (p[i]) begin
               if (m_pend[i] && i != g) nd++;
               np[i] = 1'b1;
            end
         end
      end
      if (g >= 0) begin
         m_q.push_back(g);
         m_ptr = (g + 1) % N;
      end
      m_pend = np;
      m_drop = (m_drop + nd > 255) ? 255 : m_drop + nd;
      if (nd > 0) m_ovf = 1'b1;
   endtask

   task automatic check_model();
      chk("evt_valid", evt_valid, m_q.size() > 0);
      if (m_q.size() > 0) chk("evt_id", evt_id, m_q[0]);
      chk("pend", pend, m_pend);
      chk("drop_cnt", drop_cnt, m_drop);
      chk("overflow", overflow, m_ovf);
   endtask

   task automatic cyc(input bit r, input bit e, input bit f, input logic [3:0] p, input bit rd);
      rst = r; en = e; flush = f; btn_pulse = p; evt_ready = rd;
      if (r && !f && evt_valid && rd) pops.push_back(int'(evt_id));
      model_step(r, e, f, p, rd);
      @(posedge clk);
      #1;
      if (use_model) check_model();
   endtask

   typedef struct {
      bit         r, e, f;
      logic [3:0] p;
      bit         rd;
      bit         xv;
      logic [1:0] xid;
      bit         cid;
      logic [3:0] xpend;
      logic [7:0] xdrop;
      bit         xovf;
   } vec_t;

   function automatic vec_t mk(bit r, bit e, bit f, logic [3:0] p, bit rd,
                               bit xv, logic [1:0] xid, bit cid, logic [3:0] xpend);
      vec_t v;
      v.r = r; v.e = e; v.f = f; v.p = p; v.rd = rd;
      v.xv = xv; v.xid = xid; v.cid = cid; v.xpend = xpend;
      v.xdrop = 8'd0; v.xovf = 1'b0;
      return v;
   endfunction

   initial begin
      vec_t tbl[16];
      int   exp_seq[5];
      bit   seen2;

      rst = 1'b0; en = 1'b1; flush = 1'b0; btn_pulse = '0; evt_ready = 1'b1;

      tbl[0]  = mk(0,1,0,4'b0000,1, 0,2'd0,1, 4'b0000);
      tbl[1]  = mk(1,1,0,4'b0010,1, 0,2'd0,0, 4'b0010);
      tbl[2]  = mk(1,1,0,4'b0000,1, 1,2'd1,1, 4'b0000);
      tbl[3]  = mk(1,1,0,4'b0000,1, 0,2'd0,0, 4'b0000);
      tbl[4]  = mk(0,1,0,4'b0000,1, 0,2'd0,1, 4'b0000);
      tbl[5]  = mk(1,1,0,4'b1011,1, 0,2'd0,0, 4'b1011);
      tbl[6]  = mk(1,1,0,4'b0000,1, 1,2'd0,1, 4'b1010);
      tbl[7]  = mk(1,1,0,4'b0000,1, 1,2'd1,1, 4'b1000);
      tbl[8]  = mk(1,1,0,4'b0000,1, 1,2'd3,1, 4'b0000);
      tbl[9]  = mk(1,1,0,4'b0000,1, 0,2'd0,0, 4'b0000);
      tbl[10] = mk(1,0,0,4'b1111,1, 0,2'd0,0, 4'b0000);
      tbl[11] = mk(1,1,0,4'b0100,0, 0,2'd0,0, 4'b0100);
      tbl[12] = mk(1,1,0,4'b0100,0, 1,2'd2,1, 4'b0100);
      tbl[13] = mk(1,1,0,4'b0000,0, 1,2'd2,1, 4'b0000);
      tbl[14] = mk(1,1,0,4'b0000,1, 1,2'd2,1, 4'b0000);
      tbl[15] = mk(1,1,0,4'b0000,1, 0,2'd0,0, 4'b0000);

      for (int i = 0; i < 16; i++) begin
         cyc(tbl[i].r, tbl[i].e, tbl[i].f, tbl[i].p, tbl[i].rd);
         chk($sformatf("vec%0d.evt_valid", i), evt_valid, tbl[i].xv);
         if (tbl[i].cid) chk($sformatf("vec%0d.evt_id", i), evt_id, tbl[i].xid);
         chk($sformatf("vec%0d.pend", i), pend, tbl[i].xpend);
         chk($sformatf("vec%0d.drop_cnt", i), drop_cnt, tbl[i].xdrop);
         chk($sformatf("vec%0d.overflow", i), overflow, tbl[i].xovf);
      end

      use_model = 1;

      // Backpressure: fill the FIFO, leave one request pending, then force a drop.
      cyc(0,1,0,4'b0000,0);
      cyc(1,1,0,4'b0001,0);
      cyc(1,1,0,4'b0010,0);
      cyc(1,1,0,4'b0100,0);
      cyc(1,1,0,4'b1000,0);
      cyc(1,1,0,4'b0001,0);
      cyc(1,1,0,4'b0000,0);
      chk("full.pend", pend, 4'b0001);
      chk("full.head", evt_id, 2'd0);
      cyc(1,1,0,4'b0001,0);
      chk("drop.cnt", drop_cnt, 8'd1);
      chk("drop.ovf", overflow, 1'b1);
      pops.delete();
      for (int i = 0; i < 8; i++) cyc(1,1,0,4'b0000,1);
      exp_seq = '{0, 1, 2, 3, 0};
      chk("drain.len", pops.size(), 5);
      for (int i = 0; i < 5 && i < pops.size(); i++)
         chk($sformatf("drain.id%0d", i), pops[i], exp_seq[i]);

      // Flush with FIFO partly full and overflow still set.
      cyc(1,1,0,4'b0011,0);
      cyc(1,1,0,4'b0000,0);
      cyc(1,1,0,4'b0000,0);
      cyc(1,1,1,4'b1111,0);
      chk("flush.valid", evt_valid, 1'b0);
      chk("flush.ovf", overflow, 1'b0);
      chk("flush.drop", drop_cnt, 8'd1);

      // Reset mid-handshake.
      cyc(1,1,0,4'b0110,1);
      cyc(1,1,0,4'b0000,1);
      cyc(0,1,0,4'b1111,1);
      chk("rst.valid", evt_valid, 1'b0);
      chk("rst.id", evt_id, 2'd0);

      // Pointer wrap: rr_ptr=3 with pend 1001 grants 3 before 0.
      pops.delete();
      cyc(1,1,0,4'b0100,1);
      cyc(1,1,0,4'b0000,1);
      cyc(1,1,0,4'b1001,1);
      for (int i = 0; i < 4; i++) cyc(1,1,0,4'b0000,1);
      chk("wrap.len", pops.size(), 3);
      if (pops.size() == 3) begin
         chk("wrap.id0", pops[0], 2);
         chk("wrap.id1", pops[1], 3);
         chk("wrap.id2", pops[2], 0);
      end

      // Button 0 pulsing every cycle must not starve button 2.
      pops.delete();
      cyc(1,1,0,4'b0101,1);
      for (int i = 0; i < 8; i++) cyc(1,1,0,4'b0001,1);
      seen2 = 0;
      foreach (pops[i]) if (pops[i] == 2) seen2 = 1;
      chk("fair.btn2", seen2, 1'b1);

      // Drop counter saturation: FIFO full, all buttons pulsing every cycle.
      cyc(0,1,0,4'b0000,0);
      for (int i = 0; i < 80; i++) cyc(1,1,0,4'b1111,0);
      chk("sat.drop", drop_cnt, 8'd255);

      // Randomised traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         bit rd;
         logic [3:0] p;
         rd = ((i / 64) % 2 == 1) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
         p  = 4'($urandom_range(0, 15) & $urandom_range(0, 15));
         cyc($urandom_range(0, 199) != 0, $urandom_range(0, 9) != 0,
             $urandom_range(0, 99) == 0, p, rd);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
